i2c_slave_fsm: RTL and testbench

Parametrised main controller for the APB I2C slave, the successor to the single-address slave controller. It sits between the bit-level slave data path (shift registers, SDA/SCL sync, start/stop detect, ack timer) and the TX/RX FIFOs. It adds internal multi-slot 7/10-bit address matching, general call, repeated START, and 10-bit read re-addressing. It also adds real SCL clock stretching with a timeout, and sticky-free status pulses for underrun, overrun and NACK.

---
 rtl/i2c_slave_pkg.sv | 16 +
 rtl/i2c_slave_fsm_if.sv | 33 +++
 rtl/i2c_addr_match.sv | 40 ++++
 rtl/i2c_slave_fsm.sv | 172 +++++++++++++++++
 tb/tb_i2c_slave_fsm.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state encoding and bus constants for the I2C slave controller.
package i2c_slave_pkg;

    typedef enum logic [4:0] {
        IDLE, GET_ADDR_1, CHECK_ADDR_1, ACK_HI, GET_ADDR_2, CHECK_ADDR_2, ACK_ADDR, NACK_WAIT,
        TX_WAIT, LOAD, TX_DATA, TX_ACK, TX_ACKED, RX_DATA, RX_DECIDE, RX_ACK, RX_NACK
    } state_e;

    localparam logic [1:0] SDA_LISTEN = 2'b00;
    localparam logic [1:0] SDA_ACK    = 2'b01;
    localparam logic [1:0] SDA_NACK   = 2'b10;
    localparam logic [1:0] SDA_TX     = 2'b11;

    localparam logic [4:0] HDR10 = 5'b11110;

endpackage

// File: rtl/i2c_slave_fsm_if.sv
// i2c_slave_fsm_if: data-path/FIFO side signals of the I2C slave controller.
interface i2c_slave_fsm_if #(
    parameter int NUM_ADDR = 2,
    parameter int SLOT_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
);
    logic                     start, stop, ack_prep, ack_check, ack_done, SDA_sync;
    logic [7:0]               rx_byte;
    logic [10*NUM_ADDR-1:0]   slot_addr;
    logic [NUM_ADDR-1:0]      slot_mode10, slot_en;
    logic                     gc_en, stretch_en, TX_fifo_empty, RX_fifo_full;
    logic                     rx_enable, tx_enable, load_data;
    logic                     TX_read_enable_slave, RX_write_enable_slave;
    logic [1:0]               sda_mode;
    logic                     scl_hold, busy_slave, rw_mode, general_call;
    logic [SLOT_W-1:0]        matched_slot;
    logic                     tx_nack, rx_overrun, tx_underrun, stretch_timeout;

    modport slave (
        input  start, stop, ack_prep, ack_check, ack_done, SDA_sync, rx_byte,
               slot_addr, slot_mode10, slot_en, gc_en, stretch_en, TX_fifo_empty, RX_fifo_full,
        output rx_enable, tx_enable, load_data, TX_read_enable_slave, RX_write_enable_slave,
               sda_mode, scl_hold, busy_slave, rw_mode, general_call, matched_slot,
               tx_nack, rx_overrun, tx_underrun, stretch_timeout
    );

    modport master (
        output start, stop, ack_prep, ack_check, ack_done, SDA_sync, rx_byte,
               slot_addr, slot_mode10, slot_en, gc_en, stretch_en, TX_fifo_empty, RX_fifo_full,
        input  rx_enable, tx_enable, load_data, TX_read_enable_slave, RX_write_enable_slave,
               sda_mode, scl_hold, busy_slave, rw_mode, general_call, matched_slot,
               tx_nack, rx_overrun, tx_underrun, stretch_timeout
    );
endinterface

// File: rtl/i2c_addr_match.sv
// i2c_addr_match: combinational own-address compare across all slots, lowest index wins.
module i2c_addr_match
    import i2c_slave_pkg::*;
#(
    parameter int NUM_ADDR = 2,
    parameter int SLOT_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic [7:0]             addr_byte_i,
    input  logic [SLOT_W-1:0]      cand_i,
    input  logic [10*NUM_ADDR-1:0] slot_addr_i,
    input  logic [NUM_ADDR-1:0]    slot_mode10_i,
    input  logic [NUM_ADDR-1:0]    slot_en_i,
    input  logic [NUM_ADDR-1:0]    hi10_i,
    output logic                   hit_7_o,
    output logic                   hit_hi10_o,
    output logic                   hit_lo10_o,
    output logic [SLOT_W-1:0]      slot_o
);
    logic [NUM_ADDR-1:0] v7, vhi;

    always_comb begin
        v7         = '0;
        vhi        = '0;
        hit_lo10_o = 1'b0;
        slot_o     = '0;
        for (int i = 0; i < NUM_ADDR; i++) begin
            v7[i]  = slot_en_i[i] && !slot_mode10_i[i] && slot_addr_i[i*10 +: 7] == addr_byte_i[7:1];
            // a read header only counts once the full 10-bit write address was seen for this slot
            vhi[i] = slot_en_i[i] && slot_mode10_i[i] && addr_byte_i[7:3] == HDR10
                     && addr_byte_i[2:1] == slot_addr_i[i*10+8 +: 2] && (!addr_byte_i[0] || hi10_i[i]);
            if (SLOT_W'(i) == cand_i)
                hit_lo10_o = slot_en_i[i] && slot_mode10_i[i] && addr_byte_i == slot_addr_i[i*10 +: 8];
        end
        for (int i = NUM_ADDR - 1; i >= 0; i--)
            if ((|vhi) ? vhi[i] : v7[i]) slot_o = SLOT_W'(i);
    end

    assign hit_7_o    = |v7;
    assign hit_hi10_o = |vhi;
endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C slave main controller with multi-slot 7/10-bit addressing,
// general call, repeated START and SCL stretching with timeout.
module i2c_slave_fsm
    import i2c_slave_pkg::*;
#(
    parameter int NUM_ADDR        = 2,
    parameter int STRETCH_TIMEOUT = 1024,
    parameter int SLOT_W          = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input logic            clk,
    input logic            n_rst,
    i2c_slave_fsm_if.slave bus
);
    localparam int CNT_W = (STRETCH_TIMEOUT > 0) ? $clog2(STRETCH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((STRETCH_TIMEOUT > 0) ? STRETCH_TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic [7:0]          byte_q, byte_d;
    logic [SLOT_W-1:0]   cand_q, cand_d, slot_q, slot_d, slot;
    logic [NUM_ADDR-1:0] hi10_q, hi10_d;
    logic                rw_q, rw_d, gc_q, gc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                nack_q, nack_d, ov_q, ov_d, un_q, un_d, to_q, to_d;
    logic                hit_7, hit_hi10, hit_lo10, hold, push;

    i2c_addr_match #(.NUM_ADDR(NUM_ADDR), .SLOT_W(SLOT_W)) u_match (
        .addr_byte_i  (byte_q),
        .cand_i       (cand_q),
        .slot_addr_i  (bus.slot_addr),
        .slot_mode10_i(bus.slot_mode10),
        .slot_en_i    (bus.slot_en),
        .hi10_i       (hi10_q),
        .hit_7_o      (hit_7),
        .hit_hi10_o   (hit_hi10),
        .hit_lo10_o   (hit_lo10),
        .slot_o       (slot)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        cand_d  = cand_q;
        hi10_d  = hi10_q;
        rw_d    = rw_q;
        gc_d    = gc_q;
        slot_d  = slot_q;
        nack_d  = 1'b0;
        ov_d    = 1'b0;
        un_d    = 1'b0;
        to_d    = 1'b0;
        push    = 1'b0;
        hold    = bus.stretch_en && ((state_q == TX_WAIT && bus.TX_fifo_empty)
                                  || (state_q == RX_DECIDE && bus.RX_fifo_full));
        cnt_d   = hold ? cnt_q + 1'b1 : '0;
        if (bus.stop) begin
            state_d = IDLE;
            hi10_d  = '0;
        end else if (bus.start) begin
            state_d = GET_ADDR_1;
        end else if (STRETCH_TIMEOUT != 0 && hold && cnt_q == TO_LAST) begin
            state_d = IDLE;
            to_d    = 1'b1;
        end else begin
            case (state_q)
                GET_ADDR_1, GET_ADDR_2: if (bus.ack_prep) begin
                    byte_d  = bus.rx_byte;
                    state_d = (state_q == GET_ADDR_1) ? CHECK_ADDR_1 : CHECK_ADDR_2;
                end
                CHECK_ADDR_1: begin
                    hi10_d  = (hit_hi10 && byte_q[0]) ? hi10_q : '0;
                    cand_d  = slot;
                    state_d = hit_hi10 ? (byte_q[0] ? ACK_ADDR : ACK_HI)
                            : (hit_7 || (byte_q == 8'h00 && bus.gc_en)) ? ACK_ADDR : NACK_WAIT;
                    if (state_d == ACK_ADDR) begin
                        rw_d   = byte_q[0];
                        gc_d   = !hit_hi10 && !hit_7;
                        slot_d = slot;
                    end
                end
                CHECK_ADDR_2: if (hit_lo10) begin
                    hi10_d         = '0;
                    hi10_d[cand_q] = 1'b1;
                    state_d        = ACK_ADDR;
                    rw_d           = 1'b0;
                    gc_d           = 1'b0;
                    slot_d         = cand_q;
                end else begin
                    state_d = NACK_WAIT;
                end
                ACK_HI:    if (bus.ack_done) state_d = GET_ADDR_2;
                ACK_ADDR:  if (bus.ack_done) state_d = rw_q ? TX_WAIT : RX_DATA;
                TX_WAIT: if (!bus.TX_fifo_empty) begin
                    state_d = LOAD;
                end else if (!bus.stretch_en) begin
                    un_d    = 1'b1;
                    state_d = LOAD;
                end
                LOAD:      state_d = TX_DATA;
                TX_DATA:   if (bus.ack_prep) state_d = TX_ACK;
                TX_ACK: if (bus.ack_check) begin
                    nack_d  = bus.SDA_sync;
                    state_d = bus.SDA_sync ? NACK_WAIT : TX_ACKED;
                end
                TX_ACKED:  if (bus.ack_done) state_d = TX_WAIT;
                RX_DATA:   if (bus.ack_prep) state_d = RX_DECIDE;
                RX_DECIDE: if (!bus.RX_fifo_full) begin
                    push    = 1'b1;
                    state_d = RX_ACK;
                end else if (!bus.stretch_en) begin
                    ov_d    = 1'b1;
                    state_d = RX_NACK;
                end
                RX_ACK:    if (bus.ack_done) state_d = RX_DATA;
                RX_NACK:   if (bus.ack_done) state_d = NACK_WAIT;
                default:   state_d = state_q;
            endcase
        end
        if (state_d == IDLE) begin
            rw_d   = 1'b0;
            gc_d   = 1'b0;
            slot_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            byte_q  <= '0;
            cand_q  <= '0;
            hi10_q  <= '0;
            rw_q    <= 1'b0;
            gc_q    <= 1'b0;
            slot_q  <= '0;
            cnt_q   <= '0;
            nack_q  <= 1'b0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            cand_q  <= cand_d;
            hi10_q  <= hi10_d;
            rw_q    <= rw_d;
            gc_q    <= gc_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            nack_q  <= nack_d;
            ov_q    <= ov_d;
            un_q    <= un_d;
            to_q    <= to_d;
        end
    end

    assign bus.busy_slave            = state_q != IDLE;
    assign bus.sda_mode              = (state_q inside {ACK_HI, ACK_ADDR, RX_ACK}) ? SDA_ACK
                                     : (state_q inside {NACK_WAIT, RX_NACK}) ? SDA_NACK
                                     : (state_q == TX_DATA) ? SDA_TX : SDA_LISTEN;
    assign bus.rx_enable             = state_q == RX_DATA;
    assign bus.tx_enable             = state_q == TX_DATA;
    assign bus.load_data             = state_q == LOAD;
    assign bus.TX_read_enable_slave  = state_q == LOAD;
    assign bus.RX_write_enable_slave = push;
    assign bus.scl_hold              = hold;
    assign bus.rw_mode               = rw_q;
    assign bus.general_call          = gc_q;
    assign bus.matched_slot          = slot_q;
    assign bus.tx_nack               = nack_q;
    assign bus.rx_overrun            = ov_q;
    assign bus.tx_underrun           = un_q;
    assign bus.stretch_timeout       = to_q;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: directed bus scenarios for the I2C slave controller with hand-computed expectations.
module tb_i2c_slave_fsm;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int checks = 0, errors = 0;
    int pushes = 0, pops = 0, holds = 0;
    int p0, h0;

    always #5 clk = ~clk;

    i2c_slave_fsm_if #(.NUM_ADDR(2)) bus();

    i2c_slave_fsm #(.NUM_ADDR(2), .STRETCH_TIMEOUT(16)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always @(negedge clk) begin
        if (bus.RX_write_enable_slave) pushes++;
        if (bus.TX_read_enable_slave) pops++;
        if (bus.scl_hold) holds++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic bus_stop();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte = b; bus.ack_prep = 1'b1; step(); bus.ack_prep = 1'b0;
    endtask

    task automatic ack_done_p();
        bus.ack_done = 1'b1; step(); bus.ack_done = 1'b0;
    endtask

    task automatic ack_check_p(input logic sda);
        bus.SDA_sync = sda; bus.ack_check = 1'b1; step(); bus.ack_check = 1'b0;
    endtask

    initial begin
        {bus.start, bus.stop, bus.ack_prep, bus.ack_check, bus.ack_done, bus.SDA_sync} = '0;
        bus.rx_byte       = 8'h00;
        bus.slot_addr     = {10'h02A, 10'h2C5};
        bus.slot_mode10   = 2'b01;
        bus.slot_en       = 2'b11;
        bus.gc_en         = 1'b0;
        bus.stretch_en    = 1'b0;
        bus.TX_fifo_empty = 1'b0;
        bus.RX_fifo_full  = 1'b0;
        step(3);
        n_rst = 1'b1;
        step();
        chk("reset busy", bus.busy_slave, 0);
        chk("reset sda_mode", bus.sda_mode, 0);
        chk("reset matched_slot", bus.matched_slot, 0);
        chk("reset scl_hold", bus.scl_hold, 0);

        // 7-bit write to slot 1 (0x2A), two data bytes
        p0 = pushes;
        bus_start();
        chk("w7 busy", bus.busy_slave, 1);
        send_byte(8'h54);
        chk("w7 check latency", bus.sda_mode, 0);
        step();
        chk("w7 addr ack", bus.sda_mode, 1);
        chk("w7 matched_slot", bus.matched_slot, 1);
        chk("w7 rw_mode", bus.rw_mode, 0);
        ack_done_p();
        chk("w7 rx_enable", bus.rx_enable, 1);
        send_byte(8'h11);
        step();
        chk("w7 data1 ack", bus.sda_mode, 1);
        ack_done_p();
        send_byte(8'h22);
        step();
        chk("w7 data2 ack", bus.sda_mode, 1);
        ack_done_p();
        bus_stop();
        chk("w7 pushes", pushes - p0, 2);
        chk("w7 busy after stop", bus.busy_slave, 0);
        chk("w7 slot cleared", bus.matched_slot, 0);

        // 10-bit write to slot 0 (0x2C5), repeated START, 10-bit read, master NACK
        p0 = pops;
        bus_start();
        send_byte(8'hF4);
        step();
        chk("w10 hi ack", bus.sda_mode, 1);
        ack_done_p();
        send_byte(8'hC5);
        step();
        chk("w10 lo ack", bus.sda_mode, 1);
        chk("w10 rw_mode", bus.rw_mode, 0);
        ack_done_p();
        chk("w10 rx_enable", bus.rx_enable, 1);
        bus_start();
        send_byte(8'hF5);
        step();
        chk("r10 ack", bus.sda_mode, 1);
        chk("r10 rw_mode", bus.rw_mode, 1);
        chk("r10 matched_slot", bus.matched_slot, 0);
        ack_done_p();
        step();
        chk("r10 load_data", bus.load_data, 1);
        step();
        chk("r10 tx sda_mode", bus.sda_mode, 3);
        chk("r10 pops", pops - p0, 1);
        send_byte(8'h00);
        ack_check_p(1'b1);
        chk("tx_nack pulse", bus.tx_nack, 1);
        chk("tx_nack sda", bus.sda_mode, 2);
        step();
        chk("tx_nack one cycle", bus.tx_nack, 0);
        bus_stop();

        // read header without a preceding write address: hi10 was cleared by stop
        bus_start();
        send_byte(8'hF5);
        step();
        chk("r10 no hi10 nack", bus.sda_mode, 2);
        bus_stop();

        // TX FIFO empty with stretching: 16 cycles of hold then timeout
        bus.stretch_en = 1'b1;
        bus.TX_fifo_empty = 1'b1;
        bus_start();
        send_byte(8'h55);
        step();
        chk("r7 rw_mode", bus.rw_mode, 1);
        h0 = holds;
        ack_done_p();
        chk("stretch hold", bus.scl_hold, 1);
        for (int i = 0; i < 40 && bus.busy_slave; i++) step();
        chk("stretch idle", bus.busy_slave, 0);
        chk("stretch_timeout pulse", bus.stretch_timeout, 1);
        chk("stretch hold cycles", holds - h0, 16);
        chk("stretch released", bus.scl_hold, 0);
        step();
        chk("stretch_timeout one cycle", bus.stretch_timeout, 0);
        bus.stretch_en = 1'b0;
        bus.TX_fifo_empty = 1'b0;

        // RX FIFO full without stretching: overrun, NACK, no push
        bus.RX_fifo_full = 1'b1;
        p0 = pushes;
        bus_start();
        send_byte(8'h54);
        step();
        ack_done_p();
        send_byte(8'h33);
        step();
        chk("overrun pulse", bus.rx_overrun, 1);
        chk("overrun nack", bus.sda_mode, 2);
        chk("overrun no push", pushes - p0, 0);
        ack_done_p();
        chk("overrun nack_wait", bus.sda_mode, 2);
        bus_stop();
        bus.RX_fifo_full = 1'b0;

        // general call accepted, then refused, then an unmatched address
        bus.gc_en = 1'b1;
        bus_start();
        send_byte(8'h00);
        step();
        chk("gc ack", bus.sda_mode, 1);
        chk("gc flag", bus.general_call, 1);
        bus_stop();
        chk("gc cleared", bus.general_call, 0);
        bus.gc_en = 1'b0;
        bus_start();
        send_byte(8'h00);
        step();
        chk("gc off nack", bus.sda_mode, 2);
        bus_stop();
        bus_start();
        send_byte(8'hA0);
        step(3);
        chk("unmatched nack", bus.sda_mode, 2);
        chk("unmatched busy", bus.busy_slave, 1);
        bus_stop();
        chk("unmatched idle", bus.busy_slave, 0);

        // asynchronous reset while driving TX data
        bus_start();
        send_byte(8'h55);
        step();
        ack_done_p();
        step(2);
        chk("pre-reset tx", bus.sda_mode, 3);
        #2 n_rst = 1'b0;
        #1;
        chk("async rst sda_mode", bus.sda_mode, 0);
        chk("async rst tx_enable", bus.tx_enable, 0);
        chk("async rst busy", bus.busy_slave, 0);
        chk("async rst rw_mode", bus.rw_mode, 0);
        step();
        n_rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
